// File: rtl/bram_sort_master.sv
// In-place bubble sort engine mastering a single-port block RAM.
// Reads pairs, compares unsigned, swaps with two writes, exits early.
module bram_sort_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int SWAP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDRESS_WIDTH:0]    len,
    output logic                      busy,
    output logic                      done,
    output logic [SWAP_CNT_WIDTH-1:0] swaps,
    output logic                      mem_cs,
    output logic                      mem_oe,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]     mem_din,
    input  logic [DATA_WIDTH-1:0]     mem_dout
);

    localparam int IW = ADDRESS_WIDTH + 1;
    localparam logic [IW-1:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    typedef enum logic [3:0] {
        IDLE, RD_A, CAP_A, RD_B, CAP_B, CMP, WR_A, WR_B, DONE
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]             len_q, len_nxt;
    logic [IW-1:0]             pass_q, pass_nxt;
    logic [IW-1:0]             idx_q, idx_nxt;
    logic [DATA_WIDTH-1:0]     a_q, a_nxt;
    logic [DATA_WIDTH-1:0]     b_q, b_nxt;
    logic                      swapped_q, swapped_nxt;
    logic [SWAP_CNT_WIDTH-1:0] swaps_q, swaps_nxt;

    logic [IW-1:0]            len_clamp;
    logic [IW-1:0]            last_idx;
    logic [IW-1:0]            last_pass;
    logic [ADDRESS_WIDTH-1:0] addr_i;
    logic [ADDRESS_WIDTH-1:0] addr_i1;
    logic                     step;

    assign len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
    assign last_pass = len_q - IW'(2);
    assign last_idx  = last_pass - pass_q;
    // i+1 never exceeds len-1, so the narrow increment cannot wrap
    assign addr_i    = idx_q[ADDRESS_WIDTH-1:0];
    assign addr_i1   = addr_i + ADDRESS_WIDTH'(1);
    assign swaps     = swaps_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            pass_q    <= '0;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
            swaps_q   <= '0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            pass_q    <= pass_nxt;
            idx_q     <= idx_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            swapped_q <= swapped_nxt;
            swaps_q   <= swaps_nxt;
        end
    end

    // Next-state, datapath updates and RAM port drive
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        pass_nxt    = pass_q;
        idx_nxt     = idx_q;
        a_nxt       = a_q;
        b_nxt       = b_q;
        swapped_nxt = swapped_q;
        swaps_nxt   = swaps_q;
        step        = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        mem_cs      = 1'b0;
        mem_oe      = 1'b0;
        mem_we      = 1'b0;
        mem_address = '0;
        mem_din     = '0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    swaps_nxt = '0;
                    if (len_clamp <= IW'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        len_nxt     = len_clamp;
                        pass_nxt    = '0;
                        idx_nxt     = '0;
                        swapped_nxt = 1'b0;
                        state_nxt   = RD_A;
                    end
                end
            end
            RD_A: begin
                mem_cs      = 1'b1;
                mem_oe      = 1'b1;
                mem_address = addr_i;
                state_nxt   = CAP_A;
            end
            CAP_A: begin
                mem_cs      = 1'b1;
                mem_oe      = 1'b1;
                mem_address = addr_i;
                a_nxt       = mem_dout;
                state_nxt   = RD_B;
            end
            RD_B: begin
                mem_cs      = 1'b1;
                mem_oe      = 1'b1;
                mem_address = addr_i1;
                state_nxt   = CAP_B;
            end
            CAP_B: begin
                mem_cs      = 1'b1;
                mem_oe      = 1'b1;
                mem_address = addr_i1;
                b_nxt       = mem_dout;
                state_nxt   = CMP;
            end
            CMP: begin
                if (a_q > b_q) begin
                    swapped_nxt = 1'b1;
                    if (swaps_q != '1) begin
                        swaps_nxt = swaps_q + SWAP_CNT_WIDTH'(1);
                    end
                    state_nxt = WR_A;
                end else begin
                    step = 1'b1;
                end
            end
            WR_A: begin
                mem_cs      = 1'b1;
                mem_we      = 1'b1;
                mem_address = addr_i;
                mem_din     = b_q;
                state_nxt   = WR_B;
            end
            WR_B: begin
                mem_cs      = 1'b1;
                mem_we      = 1'b1;
                mem_address = addr_i1;
                mem_din     = a_q;
                step        = 1'b1;
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        if (step) begin
            if (idx_q < last_idx) begin
                idx_nxt   = idx_q + IW'(1);
                state_nxt = RD_A;
            end else if (!swapped_q || pass_q == last_pass) begin
                state_nxt = DONE;
            end else begin
                pass_nxt    = pass_q + IW'(1);
                idx_nxt     = '0;
                swapped_nxt = 1'b0;
                state_nxt   = RD_A;
            end
        end
    end

endmodule

// File: tb/tb_bram_sort_master.sv
// Bench for bram_sort_master: RAM model, loader, and a reference
// model based on inversion counts and an abstract bubble-sort walk.
module tb_bram_sort_master;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [SW-1:0] swaps;
    logic          mem_cs;
    logic          mem_oe;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_din;

    logic [DW-1:0] ram [256];

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_cs   = 0;
    int n_we   = 0;
    int n_both = 0;
    int n_busy = 0;

    int cur [256];

    bram_sort_master #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .SWAP_CNT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .busy(busy),
        .done(done),
        .swaps(swaps),
        .mem_cs(mem_cs),
        .mem_oe(mem_oe),
        .mem_we(mem_we),
        .mem_address(mem_address),
        .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency; loader port used while idle
    always @(posedge clk) begin
        if (ld_we) ram[ld_addr] <= ld_din;
        else if (mem_cs && mem_we) ram[mem_address] <= mem_din;
        if (mem_cs && mem_oe) mem_dout <= ram[mem_address];
    end

    // Event counters for protocol properties
    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
        if (mem_cs) n_cs <= n_cs + 1;
        if (mem_cs && mem_we) n_we <= n_we + 1;
        if (mem_oe && mem_we) n_both <= n_both + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    function automatic int model_inv(input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (cur[i] > cur[j]) c++;
        return c;
    endfunction

    // Cycles from start to done: 5 per compare, 2 more per swap,
    // early exit on a pass without swaps, plus the DONE cycle
    function automatic int model_cycles(input int n);
        int a [256];
        int c = 1;
        int t;
        bit sw;
        a = cur;
        if (n < 2) return 1;
        for (int p = 0; p <= n - 2; p++) begin
            sw = 0;
            for (int j = 0; j <= n - 2 - p; j++) begin
                c += 5;
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    c += 2;
                    sw = 1;
                end
            end
            if (!sw) break;
        end
        return c;
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_din  = DW'(cur[i]);
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic run_sort(input int n, input int eff,
                            input int restart_at, input string tag);
        int ec, es, k, bad, want;
        int d0, c0, w0, b0;
        int q [$];
        ec = model_cycles(eff);
        es = model_inv(eff);
        d0 = n_done; c0 = n_cs; w0 = n_we; b0 = n_busy;
        @(negedge clk);
        start = 1'b1;
        len   = (AW+1)'(n);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start = (k == restart_at);
            if (k == 1 && eff >= 2) begin
                checks++;
                assert (busy === 1'b1) else begin
                    errors++;
                    $error("FAIL %s_busy got %b want 1", tag, busy);
                end
            end
        end while (!done && k < ec + 50);
        checks++;
        assert (k === ec && done === 1'b1) else begin
            errors++;
            $error("FAIL %s_latency got %0d want %0d", tag, k, ec);
        end
        if (eff >= 2) begin
            checks++;
            assert (swaps === SW'(es)) else begin
                errors++;
                $error("FAIL %s_swaps got %0d want %0d", tag, swaps, es);
            end
        end
        @(negedge clk);
        for (int i = 0; i < eff; i++) q.push_back(cur[i]);
        q.sort();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            want = (i < eff) ? q[i] : cur[i];
            if (int'(ram[i]) !== want) bad++;
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s_ram got %0d bad words want 0", tag, bad);
        end
        for (int i = 0; i < 256; i++) cur[i] = int'(ram[i]);
        checks++;
        assert (n_done - d0 === 1) else begin
            errors++;
            $error("FAIL %s_done got %0d pulses want 1", tag, n_done - d0);
        end
        if (es == 0) begin
            checks++;
            assert (n_we - w0 === 0) else begin
                errors++;
                $error("FAIL %s_nowrite got %0d writes want 0", tag, n_we - w0);
            end
        end
        if (eff <= 1) begin
            checks++;
            assert (n_cs - c0 === 0 && n_busy - b0 === 0) else begin
                errors++;
                $error("FAIL %s_idle got cs %0d busy %0d want 0 0",
                       tag, n_cs - c0, n_busy - b0);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        logic [SW+DW+AW+5:0] obs;
        obs = {busy, done, swaps, mem_cs, mem_oe, mem_we, mem_address, mem_din};
        checks++;
        assert (obs === '0) else begin
            errors++;
            $error("FAIL %s got %h want 0", tag, obs);
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; len = '0;
        ld_we = 1'b0; ld_addr = '0; ld_din = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 256; i++) cur[i] = 0;
        load(256);

        cur[0] = 3; cur[1] = 1; cur[2] = 2; cur[3] = 0;
        load(4);
        run_sort(4, 4, 0, "s3120");
        checks++;
        assert (swaps === SW'(5)) else begin
            errors++;
            $error("FAIL s3120_const got %0d want 5", swaps);
        end

        cur[0] = 1; cur[1] = 2; cur[2] = 3; cur[3] = 4;
        load(4);
        run_sort(4, 4, 0, "sorted");

        cur[0] = 5; cur[1] = 5; cur[2] = 2;
        load(3);
        run_sort(3, 3, 0, "s552");
        run_sort(1, 1, 0, "len1");
        run_sort(0, 0, 0, "len0");

        cur[0] = 3; cur[1] = 1; cur[2] = 2; cur[3] = 0;
        load(4);
        run_sort(4, 4, 10, "restart");

        cur[0] = 3; cur[1] = 1; cur[2] = 2; cur[3] = 0;
        load(4);
        @(negedge clk);
        start = 1'b1; len = 9'd4;
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!mem_we && k < 50);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        checks++;
        assert (ram[0] === 8'd1 && ram[1] === 8'd3 &&
                ram[2] === 8'd2 && ram[3] === 8'd0) else begin
            errors++;
            $error("FAIL midreset_ram got %0d %0d %0d %0d want 1 3 2 0",
                   ram[0], ram[1], ram[2], ram[3]);
        end
        for (int i = 0; i < 4; i++) cur[i] = int'(ram[i]);
        run_sort(4, 4, 0, "after_rst");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(2, 20));
            for (int i = 0; i < n; i++) cur[i] = int'($urandom_range(0, 7));
            load(n);
            run_sort(n, n, 0, "rand");
        end

        for (int i = 0; i < 96; i++) cur[i] = 95 - i;
        load(96);
        run_sort(96, 96, 0, "desc96");

        for (int i = 0; i < 256; i++) cur[i] = i;
        cur[0] = 1; cur[1] = 0; cur[254] = 255; cur[255] = 254;
        load(256);
        run_sort(300, 256, 0, "clamp");

        checks++;
        assert (n_both === 0) else begin
            errors++;
            $error("FAIL oe_we got %0d overlaps want 0", n_both);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
